// File: rtl/imem_loader_if.sv
// imem_loader_if
//   Groups the byte-stream handshake and the instruction-memory write bus
//   of the instruction-memory loader.
//
//   byte_in     [7:0]  instruction byte from the stream source
//   byte_valid         byte_in holds a valid byte
//   byte_ready         loader accepts a byte this cycle
//   WE                 instruction-memory write strobe, one cycle per word
//   W_Addr     [31:0]  word-aligned byte address of the word being written
//   W_Ins      [31:0]  assembled instruction word
//
//   slave  : the loader side (consumes bytes, drives the memory write bus)
//   master : the environment side (stream source plus instruction memory)
interface imem_loader_if;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        WE;
  logic [31:0] W_Addr;
  logic [31:0] W_Ins;

  modport master (
    output byte_in, byte_valid,
    input  byte_ready, WE, W_Addr, W_Ins
  );

  modport slave (
    input  byte_in, byte_valid,
    output byte_ready, WE, W_Addr, W_Ins
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader
//   Receives an instruction byte stream, packs it MSB-first into 32-bit
//   words and writes WORDS consecutive words into instruction memory
//   starting at byte address 0, while holding the fetch stage in reset.
//
//   Parameters
//     WORDS         words per load session, 1..256
//   Ports
//     CLK           clock, rising edge
//     RST           asynchronous active-low reset
//     start         begin a session (sampled in IDLE or DONE only)
//     abort         cancel an active session
//     bus           imem_loader_if.slave: byte handshake + memory write bus
//     core_hold     holds the fetch stage in reset while loading
//     busy          session in progress
//     done          last session completed all WORDS words
//     words_loaded  words written in the current or last session
module imem_loader #(
  parameter int WORDS = 64
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          start,
  input  logic          abort,
  imem_loader_if.slave  bus,
  output logic          core_hold,
  output logic          busy,
  output logic          done,
  output logic [8:0]    words_loaded
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [7:0] LAST_IDX = 8'(WORDS - 1);

  state_e      state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]  word_idx_q, word_idx_d;
  logic [23:0] asm_q, asm_d;
  logic [31:0] w_ins_q, w_ins_d;
  logic [31:0] w_addr_q, w_addr_d;
  logic [8:0]  words_loaded_q, words_loaded_d;
  logic        byte_ready_q, byte_ready_d;
  logic        we_q, we_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        accept;

  // A byte moves only when the registered ready and the source valid meet.
  assign accept = byte_ready_q & bus.byte_valid;

  always_comb begin
    state_d        = state_q;
    byte_cnt_d     = byte_cnt_q;
    word_idx_d     = word_idx_q;
    asm_d          = asm_q;
    w_ins_d        = w_ins_q;
    w_addr_d       = w_addr_q;
    words_loaded_d = words_loaded_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d        = RECV;
          byte_cnt_d     = 2'd0;
          word_idx_d     = 8'd0;
          words_loaded_d = 9'd0;
        end
      end
      RECV: begin
        if (abort) begin
          // Partial word is simply dropped; completed words stay counted.
          state_d    = IDLE;
          byte_cnt_d = 2'd0;
        end else if (accept) begin
          if (byte_cnt_q == 2'd3) begin
            // Fourth byte completes the word: latch data and address so
            // they are presented during the single WRITE cycle and then held.
            w_ins_d    = {asm_q, bus.byte_in};
            w_addr_d   = {22'd0, word_idx_q, 2'b00};
            byte_cnt_d = 2'd0;
            state_d    = WRITE;
          end else begin
            // After three shifts the first byte sits in asm_q[23:16].
            asm_d      = {asm_q[15:0], bus.byte_in};
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end
      end
      WRITE: begin
        words_loaded_d = words_loaded_q + 9'd1;
        if (abort) begin
          state_d = IDLE;
        end else if (word_idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          word_idx_d = word_idx_q + 8'd1;
          state_d    = RECV;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    byte_ready_d = (state_d == RECV);
    we_d         = (state_d == WRITE);
    busy_d       = (state_d == RECV) || (state_d == WRITE);
    done_d       = (state_d == DONE);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q        <= IDLE;
      byte_cnt_q     <= 2'd0;
      word_idx_q     <= 8'd0;
      asm_q          <= 24'd0;
      w_ins_q        <= 32'd0;
      w_addr_q       <= 32'd0;
      words_loaded_q <= 9'd0;
      byte_ready_q   <= 1'b0;
      we_q           <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      byte_cnt_q     <= byte_cnt_d;
      word_idx_q     <= word_idx_d;
      asm_q          <= asm_d;
      w_ins_q        <= w_ins_d;
      w_addr_q       <= w_addr_d;
      words_loaded_q <= words_loaded_d;
      byte_ready_q   <= byte_ready_d;
      we_q           <= we_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  assign bus.byte_ready = byte_ready_q;
  assign bus.WE         = we_q;
  assign bus.W_Addr     = w_addr_q;
  assign bus.W_Ins      = w_ins_q;
  // core_hold and busy share one definition: asserted in RECV and WRITE.
  assign core_hold      = busy_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign words_loaded   = words_loaded_q;

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter WORDS, default 64, number of 32-bit instruction words per load; legal range 1..256.
REQ-002 CLK  input  1  clock; all state changes on rising edge.
REQ-003 RST  input  1  reset; asynchronous assert, synchronous release, active-low.
REQ-004 start  input  1  begin a load session; sampled only in IDLE or DONE.
REQ-005 abort  input  1  cancel an active session.
REQ-006 byte_in  input  8  instruction byte stream.
REQ-007 byte_valid  input  1  byte_in holds a valid byte.
REQ-008 byte_ready  output  1  loader accepts a byte this cycle.
REQ-009 WE  output  1  instruction-memory write strobe, one cycle per word.
REQ-010 W_Addr  output  32  byte address of the word being written, word-aligned.
REQ-011 W_Ins  output  32  assembled instruction word.
REQ-012 core_hold  output  1  holds the fetch stage in reset while loading.
REQ-013 busy  output  1  session in progress.
REQ-014 done  output  1  last session completed all WORDS words.
REQ-015 words_loaded  output  9  words written in the current or last session.

Function
REQ-016 States: IDLE, RECV, WRITE, DONE; the state register and every output are registered.
REQ-017 IDLE/DONE: start=1 -> RECV next cycle; clear byte counter, word index, words_loaded; done=0.
REQ-018 Byte transfer occurs only on a cycle with byte_valid=1 and byte_ready=1; byte_ready=1 only in RECV.
REQ-019 Bytes are packed MSB-first: first accepted byte -> W_Ins[31:24], fourth -> W_Ins[7:0].
REQ-020 byte_valid without byte_ready is ignored; no byte is dropped or duplicated.
REQ-021 After the fourth accepted byte -> WRITE next cycle; byte_ready=0 in WRITE.
REQ-022 WRITE lasts exactly one cycle: WE=1, W_Addr = word_index*4, W_Ins stable; words_loaded increments on the same edge that leaves WRITE.
REQ-023 From WRITE: if word_index = WORDS-1 -> DONE, else word_index+1 and -> RECV.
REQ-024 DONE: done=1, busy=0, core_hold=0; remains until start or reset.
REQ-025 busy = core_hold = 1 in RECV and WRITE, 0 in IDLE and DONE.
REQ-026 abort=1 in RECV -> IDLE next cycle, partial word discarded, no WE, done=0, words_loaded retains the count of completed words.
REQ-027 abort=1 in WRITE: the write completes (WE=1 that cycle), then -> IDLE; abort takes priority over the DONE transition.
REQ-028 start while busy is ignored; start and abort in the same IDLE/DONE cycle -> start wins.
REQ-029 WE=0 whenever the state is not WRITE; W_Addr and W_Ins hold their last values outside WRITE.
REQ-030 W_Addr never exceeds (WORDS-1)*4; the word index does not wrap within a session.

Reset
REQ-031 RST=0 forces IDLE immediately, mid-session included: WE=0, byte_ready=0, busy=0, done=0, core_hold=0, words_loaded=0, W_Addr=0, W_Ins=0.
REQ-032 The first transition after RST release is taken on the first rising edge with RST=1.

Verification
REQ-033 WORDS=2; start, bytes 8C,01,00,04,AC,02,00,08 with continuous valid -> WE pulses with (0x00000000, 8C010004) and (0x00000004, AC020008), done=1, words_loaded=2, core_hold low in DONE.
REQ-034 Random byte_valid gaps over a full 64-word load -> 64 WE pulses, addresses 0x000..0x0FC in order, data matches the packed stream, no extra pulses.
REQ-035 Abort after 6 bytes of a WORDS=4 load -> one WE at 0x0, IDLE, words_loaded=1, done=0; a following start reloads from address 0.
REQ-036 Abort asserted in the WRITE cycle of word 3 -> WE for 0x8 occurs, then IDLE, done=0.
REQ-037 RST low for one cycle mid-word -> all outputs at reset values asynchronously, no WE, byte_ready=0 until start.
REQ-038 start held high through a session -> no restart while busy; in DONE it re-enters RECV and clears done.
